id_ex_stage_reg: RTL and testbench

//   ID/EX pipeline register with integrated load-use hazard detection.

---
 rtl/id_ex_stage_reg.sv | 234 +++++++++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register with load-use hazard detection, a WB write-through
// bypass and a saturating stall-cycle counter.
//
// Captures the decoded operands and control of the instruction in ID and
// presents them to EX one cycle later. The ex_rs1/ex_rs2/ex_rd/ex_reg_write
// outputs feed the EX-stage forwarding unit.
//
// Ports
//   clk, rstn           rising-edge clock, synchronous active-low reset
//   id_*                decoded instruction fields from ID
//   flush_i             EX branch/jump taken: squash the ID instruction
//   hold_i              downstream stall: freeze the ID/EX register
//   wb_we/wb_rd/wb_data regfile write happening in WB this cycle
//   ex_*                registered copies of the id_* fields, plus ex_valid
//   stall_o             hold PC and IF/ID this cycle (combinational)
//   stall_cnt           number of cycles stalled on load-use, saturating
// ----------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RAW   = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,

    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RAW-1:0]   id_rs1,
    input  logic [RAW-1:0]   id_rs2,
    input  logic [RAW-1:0]   id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_reg_write,

    input  logic             flush_i,
    input  logic             hold_i,

    input  logic             wb_we,
    input  logic [RAW-1:0]   wb_rd,
    input  logic [XLEN-1:0]  wb_data,

    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RAW-1:0]   ex_rs1,
    output logic [RAW-1:0]   ex_rs2,
    output logic [RAW-1:0]   ex_rd,
    output logic             ex_uses_rs1,
    output logic             ex_uses_rs2,
    output logic [4:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,

    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [RAW-1:0]   r_rs1;
    logic [RAW-1:0]   r_rs2;
    logic [RAW-1:0]   r_rd;
    logic             r_uses_rs1;
    logic             r_uses_rs2;
    logic [4:0]       r_alu_op;
    logic             r_alu_src;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_mem_to_reg;
    logic             r_reg_write;
    logic [CNT_W-1:0] r_stall_cnt;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_bubble;
    logic w_cnt_inc;
    logic w_cnt_sat;

    assign w_rs1_hit  = id_uses_rs1 & (r_rd == id_rs1);
    assign w_rs2_hit  = id_uses_rs2 & (r_rd == id_rs2);
    assign w_load_use = r_valid & r_mem_read & (r_rd != '0) & id_valid &
                        (w_rs1_hit | w_rs2_hit);

    // A taken branch squashes the ID instruction anyway, so it never needs
    // to be held back; flush therefore masks the stall request.
    assign stall_o    = ~flush_i & (hold_i | w_load_use);

    // Flush always bubbles; a load-use bubble only matters when not holding,
    // since a hold keeps the current EX contents in place.
    assign w_bubble   = flush_i | (~hold_i & w_load_use);

    assign w_cnt_inc  = w_load_use & ~flush_i & ~hold_i;
    assign w_cnt_sat  = &r_stall_cnt;

    // ------------------------------------------------------------------------
    // WB write-through bypass
    //   On a load the incoming ID indices are compared; on a hold the held
    //   EX indices are compared so frozen operands do not go stale.
    // ------------------------------------------------------------------------
    logic w_wb_live;
    logic w_byp_id_rs1;
    logic w_byp_id_rs2;
    logic w_byp_ex_rs1;
    logic w_byp_ex_rs2;

    assign w_wb_live    = wb_we & (wb_rd != '0);
    assign w_byp_id_rs1 = w_wb_live & (wb_rd == id_rs1);
    assign w_byp_id_rs2 = w_wb_live & (wb_rd == id_rs2);
    assign w_byp_ex_rs1 = w_wb_live & (wb_rd == r_rs1);
    assign w_byp_ex_rs2 = w_wb_live & (wb_rd == r_rs2);

    // ------------------------------------------------------------------------
    // Register update: reset > flush > hold > load_use > load
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_uses_rs1   <= 1'b0;
            r_uses_rs2   <= 1'b0;
            r_alu_op     <= '0;
            r_alu_src    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_bubble) begin
                r_valid      <= 1'b0;
                r_pc         <= '0;
                r_rs1_data   <= '0;
                r_rs2_data   <= '0;
                r_imm        <= '0;
                r_rs1        <= '0;
                r_rs2        <= '0;
                r_rd         <= '0;
                r_uses_rs1   <= 1'b0;
                r_uses_rs2   <= 1'b0;
                r_alu_op     <= '0;
                r_alu_src    <= 1'b0;
                r_mem_read   <= 1'b0;
                r_mem_write  <= 1'b0;
                r_mem_to_reg <= 1'b0;
                r_reg_write  <= 1'b0;
            end else if (hold_i) begin
                if (w_byp_ex_rs1) begin
                    r_rs1_data <= wb_data;
                end
                if (w_byp_ex_rs2) begin
                    r_rs2_data <= wb_data;
                end
            end else begin
                r_valid      <= id_valid;
                r_pc         <= id_pc;
                r_rs1_data   <= w_byp_id_rs1 ? wb_data : id_rs1_data;
                r_rs2_data   <= w_byp_id_rs2 ? wb_data : id_rs2_data;
                r_imm        <= id_imm;
                r_rs1        <= id_rs1;
                r_rs2        <= id_rs2;
                r_rd         <= id_rd;
                r_uses_rs1   <= id_uses_rs1;
                r_uses_rs2   <= id_uses_rs2;
                r_alu_op     <= id_alu_op;
                r_alu_src    <= id_alu_src;
                // An empty ID slot enters EX as a bubble with no side effects.
                r_mem_read   <= id_valid & id_mem_read;
                r_mem_write  <= id_valid & id_mem_write;
                r_mem_to_reg <= id_valid & id_mem_to_reg;
                r_reg_write  <= id_valid & id_reg_write;
            end

            if (w_cnt_inc && !w_cnt_sat) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_rs1_data   = r_rs1_data;
    assign ex_rs2_data   = r_rs2_data;
    assign ex_imm        = r_imm;
    assign ex_rs1        = r_rs1;
    assign ex_rs2        = r_rs2;
    assign ex_rd         = r_rd;
    assign ex_uses_rs1   = r_uses_rs1;
    assign ex_uses_rs2   = r_uses_rs2;
    assign ex_alu_op     = r_alu_op;
    assign ex_alu_src    = r_alu_src;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_reg_write  = r_reg_write;
    assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Scoreboard bench for id_ex_stage_reg: each scenario pushes the expected
// EX-side contents when it drives ID, and pops/compares after the edge.
// The stall counter is instantiated narrow (4 bits) so saturation is reachable.
// ----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RAW   = 5;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1d;
        logic [XLEN-1:0] rs2d;
        logic [XLEN-1:0] imm;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
        logic            u1;
        logic            u2;
        logic [4:0]      op;
        logic            asrc;
        logic            mr;
        logic            mw;
        logic            m2r;
        logic            rw;
    } ex_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic            flush_i;
    logic            hold_i;
    logic            wb_we;
    logic [RAW-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data;
    ex_t             id_in;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [RAW-1:0]   ex_rs1;
    logic [RAW-1:0]   ex_rs2;
    logic [RAW-1:0]   ex_rd;
    logic             ex_uses_rs1;
    logic             ex_uses_rs2;
    logic [4:0]       ex_alu_op;
    logic             ex_alu_src;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_mem_to_reg;
    logic             ex_reg_write;
    logic             stall_o;
    logic [CNT_W-1:0] stall_cnt;

    id_ex_stage_reg #(
        .XLEN  (XLEN),
        .RAW   (RAW),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .id_valid      (id_in.valid),
        .id_pc         (id_in.pc),
        .id_rs1_data   (id_in.rs1d),
        .id_rs2_data   (id_in.rs2d),
        .id_imm        (id_in.imm),
        .id_rs1        (id_in.rs1),
        .id_rs2        (id_in.rs2),
        .id_rd         (id_in.rd),
        .id_uses_rs1   (id_in.u1),
        .id_uses_rs2   (id_in.u2),
        .id_alu_op     (id_in.op),
        .id_alu_src    (id_in.asrc),
        .id_mem_read   (id_in.mr),
        .id_mem_write  (id_in.mw),
        .id_mem_to_reg (id_in.m2r),
        .id_reg_write  (id_in.rw),
        .flush_i       (flush_i),
        .hold_i        (hold_i),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_rs1_data   (ex_rs1_data),
        .ex_rs2_data   (ex_rs2_data),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_uses_rs1   (ex_uses_rs1),
        .ex_uses_rs2   (ex_uses_rs2),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_reg_write  (ex_reg_write),
        .stall_o       (stall_o),
        .stall_cnt     (stall_cnt)
    );

    int unsigned      checks   = 0;
    int unsigned      failures = 0;
    ex_t              q_exp[$];
    ex_t              exp_e;
    ex_t              got_e;
    logic [CNT_W-1:0] exp_cnt = '0;

    // ---------------------------------------------------------------- helpers
    function automatic ex_t get_ex();
        ex_t e;
        e.valid = ex_valid;      e.pc   = ex_pc;
        e.rs1d  = ex_rs1_data;   e.rs2d = ex_rs2_data;
        e.imm   = ex_imm;        e.rs1  = ex_rs1;
        e.rs2   = ex_rs2;        e.rd   = ex_rd;
        e.u1    = ex_uses_rs1;   e.u2   = ex_uses_rs2;
        e.op    = ex_alu_op;     e.asrc = ex_alu_src;
        e.mr    = ex_mem_read;   e.mw   = ex_mem_write;
        e.m2r   = ex_mem_to_reg; e.rw   = ex_reg_write;
        return e;
    endfunction

    function automatic ex_t mk(input logic v, input logic [RAW-1:0] rs1,
                               input logic [RAW-1:0] rs2, input logic [RAW-1:0] rd,
                               input logic u1, input logic u2,
                               input logic mr, input logic rw);
        ex_t e;
        e.valid = v;
        e.pc    = $urandom;
        e.rs1d  = $urandom;
        e.rs2d  = $urandom;
        e.imm   = $urandom;
        e.rs1   = rs1;
        e.rs2   = rs2;
        e.rd    = rd;
        e.u1    = u1;
        e.u2    = u2;
        e.op    = 5'($urandom);
        e.asrc  = 1'($urandom);
        e.mr    = mr;
        e.mw    = ~mr & 1'($urandom);
        e.m2r   = mr;
        e.rw    = rw;
        return e;
    endfunction

    // What EX should hold after a plain load of ins with the current WB inputs.
    function automatic ex_t model_load(input ex_t ins);
        ex_t e = ins;
        if (!ins.valid) begin
            e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.m2r = 1'b0;
        end
        if (wb_we && wb_rd != '0 && wb_rd == ins.rs1) e.rs1d = wb_data;
        if (wb_we && wb_rd != '0 && wb_rd == ins.rs2) e.rs2d = wb_data;
        return e;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rstn = 1'b0;
        id_in = mk(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        hold_i = 1'b1;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = $urandom;
        q_exp.push_back('0);
        exp_cnt = '0;
        tick();
        exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
        if (got_e !== exp_e) begin
            failures++; $display("FAIL reset_ex got=%h exp=%h", got_e, exp_e);
        end
        checks++;
        if (stall_cnt !== exp_cnt) begin
            failures++; $display("FAIL reset_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
        rstn = 1'b1; hold_i = 1'b0; wb_we = 1'b0;
        #1; checks++;
        if (stall_o !== 1'b0) begin
            failures++; $display("FAIL reset_stall got=%b exp=0", stall_o);
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 4; i++) begin
            logic [RAW-1:0] a = RAW'($urandom_range(15, 1));
            logic [RAW-1:0] b = RAW'($urandom_range(31, 16));
            wb_data = $urandom;
            case (i)
                0: begin id_in = mk(1'b1, a, b, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1); wb_we = 1'b0; wb_rd = a; end
                1: begin id_in = mk(1'b1, a, b, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1); wb_we = 1'b1; wb_rd = a; end
                2: begin id_in = mk(1'b1, '0, '0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1); wb_we = 1'b1; wb_rd = '0; end
                default: begin id_in = mk(1'b0, a, b, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1); id_in.mw = 1'b1;
                               wb_we = 1'b1; wb_rd = b; end
            endcase
            exp_e = model_load(id_in);
            q_exp.push_back(exp_e);
            #1; checks++;
            if (stall_o !== 1'b0) begin
                failures++; $display("FAIL load_stall[%0d] got=%b exp=0", i, stall_o);
            end
            tick();
            exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
            if (got_e !== exp_e) begin
                failures++; $display("FAIL load_ex[%0d] got=%h exp=%h", i, got_e, exp_e);
            end
        end
        wb_we = 1'b0;
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 2; i++) begin
            ex_t lw  = mk(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
            ex_t add = (i == 0) ? mk(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1)
                                : mk(1'b1, 5'd3, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
            id_in = lw;
            q_exp.push_back(lw);
            tick();
            exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
            if (got_e !== exp_e) begin
                failures++; $display("FAIL lu_lw[%0d] got=%h exp=%h", i, got_e, exp_e);
            end
            id_in = add;
            #1; checks++;
            if (stall_o !== 1'b1) begin
                failures++; $display("FAIL lu_stall[%0d] got=%b exp=1", i, stall_o);
            end
            q_exp.push_back('0);
            exp_cnt = sat_inc(exp_cnt);
            tick();
            exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
            if (got_e !== exp_e) begin
                failures++; $display("FAIL lu_bubble[%0d] got=%h exp=%h", i, got_e, exp_e);
            end
            checks++;
            if (stall_o !== 1'b0) begin
                failures++; $display("FAIL lu_release[%0d] got=%b exp=0", i, stall_o);
            end
            q_exp.push_back(add);
            tick();
            exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
            if (got_e !== exp_e) begin
                failures++; $display("FAIL lu_add[%0d] got=%h exp=%h", i, got_e, exp_e);
            end
            checks++;
            if (stall_cnt !== exp_cnt) begin
                failures++; $display("FAIL lu_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_no_false_stall();
        ex_t ex_tab[3];
        ex_t id_tab[3];
        ex_tab[0] = mk(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);  // lw x0
        id_tab[0] = mk(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        ex_tab[1] = mk(1'b1, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);  // lw x5
        id_tab[1] = mk(1'b1, 5'd5, 5'd5, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);  // not read
        ex_tab[2] = mk(1'b1, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);  // lw x5
        id_tab[2] = mk(1'b0, 5'd5, 5'd5, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);  // empty slot
        for (int i = 0; i < 3; i++) begin
            id_in = ex_tab[i];
            q_exp.push_back(ex_tab[i]);
            tick();
            exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
            if (got_e !== exp_e) begin
                failures++; $display("FAIL nfs_ex[%0d] got=%h exp=%h", i, got_e, exp_e);
            end
            id_in = id_tab[i];
            #1; checks++;
            if (stall_o !== 1'b0) begin
                failures++; $display("FAIL nfs_stall[%0d] got=%b exp=0", i, stall_o);
            end
            q_exp.push_back(model_load(id_tab[i]));
            tick();
            exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
            if (got_e !== exp_e) begin
                failures++; $display("FAIL nfs_id[%0d] got=%h exp=%h", i, got_e, exp_e);
            end
        end
    endtask

    task automatic test_flush_load_use();
        for (int i = 0; i < 2; i++) begin
            ex_t lw = mk(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
            id_in = lw;
            q_exp.push_back(lw);
            tick();
            void'(q_exp.pop_front());
            id_in = mk(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
            flush_i = 1'b1;
            hold_i  = (i == 1);
            #1; checks++;
            if (stall_o !== 1'b0) begin
                failures++; $display("FAIL flush_stall[%0d] got=%b exp=0", i, stall_o);
            end
            q_exp.push_back('0);
            tick();
            flush_i = 1'b0; hold_i = 1'b0;
            exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
            if (got_e !== exp_e) begin
                failures++; $display("FAIL flush_ex[%0d] got=%h exp=%h", i, got_e, exp_e);
            end
            checks++;
            if (stall_cnt !== exp_cnt) begin
                failures++; $display("FAIL flush_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_hold();
        ex_t held = mk(1'b1, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        id_in = held;
        q_exp.push_back(held);
        tick();
        exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
        if (got_e !== exp_e) begin
            failures++; $display("FAIL hold_load got=%h exp=%h", got_e, exp_e);
        end
        // ID depends on the held load, so load_use is also asserted.
        id_in = mk(1'b1, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        hold_i = 1'b1; wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1; checks++;
            if (stall_o !== 1'b1) begin
                failures++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, stall_o);
            end
            exp_e = held;
            exp_e.rs1d = 32'hDEAD_BEEF;
            q_exp.push_back(exp_e);
            tick();
            exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
            if (got_e !== exp_e) begin
                failures++; $display("FAIL hold_ex[%0d] got=%h exp=%h", i, got_e, exp_e);
            end
            checks++;
            if (stall_cnt !== exp_cnt) begin
                failures++; $display("FAIL hold_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, exp_cnt);
            end
        end
        hold_i = 1'b0; wb_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        flush_i = 1'b1;
        q_exp.push_back('0);
        tick();
        flush_i = 1'b0;
        exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
        if (got_e !== exp_e) begin
            failures++; $display("FAIL b2b_flush got=%h exp=%h", got_e, exp_e);
        end
        for (int i = 0; i < 8; i++) begin
            id_in = mk(1'($urandom), RAW'($urandom), RAW'($urandom), RAW'($urandom),
                       1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
            wb_we   = 1'($urandom);
            wb_rd   = (i % 2 == 0) ? id_in.rs1 : RAW'($urandom);
            wb_data = $urandom;
            q_exp.push_back(model_load(id_in));
            tick();
            exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
            if (got_e !== exp_e) begin
                failures++; $display("FAIL b2b_ex[%0d] got=%h exp=%h", i, got_e, exp_e);
            end
        end
        wb_we = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            ex_t lw = mk(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
            id_in = lw;
            q_exp.push_back(lw);
            tick();
            void'(q_exp.pop_front());
            id_in = mk(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
            #1;
            if (stall_o !== 1'b1) begin
                checks++; failures++;
                $display("FAIL sat_stall[%0d] got=%b exp=1", i, stall_o);
            end
            exp_cnt = sat_inc(exp_cnt);
            q_exp.push_back('0);
            tick();
            exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
            if (got_e !== exp_e) begin
                failures++; $display("FAIL sat_bubble[%0d] got=%h exp=%h", i, got_e, exp_e);
            end
            checks++;
            if (stall_cnt !== exp_cnt) begin
                failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, exp_cnt);
            end
        end
        checks++;
        if (stall_cnt !== 4'hF) begin
            failures++; $display("FAIL sat_final got=%h exp=f", stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        ex_t lw  = mk(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        ex_t add = mk(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        id_in = lw;
        q_exp.push_back(lw);
        tick();
        void'(q_exp.pop_front());
        id_in = add;
        rstn = 1'b0;
        q_exp.push_back('0);
        exp_cnt = '0;
        tick();
        rstn = 1'b1;
        exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
        if (got_e !== exp_e) begin
            failures++; $display("FAIL rms_ex got=%h exp=%h", got_e, exp_e);
        end
        checks++;
        if (stall_cnt !== exp_cnt) begin
            failures++; $display("FAIL rms_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
        #1; checks++;
        if (stall_o !== 1'b0) begin
            failures++; $display("FAIL rms_stall got=%b exp=0", stall_o);
        end
        q_exp.push_back(add);
        tick();
        exp_e = q_exp.pop_front(); got_e = get_ex(); checks++;
        if (got_e !== exp_e) begin
            failures++; $display("FAIL rms_add got=%h exp=%h", got_e, exp_e);
        end
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        rstn = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        id_in = '0;
        test_reset();
        test_load();
        test_load_use();
        test_no_false_stall();
        test_flush_load_use();
        test_hold();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
